// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle control FSM for an RV32I datapath sharing one memory port for fetch and data.
// Define ILLEGAL_TRAP_EN to park illegal opcodes in TRAP and expose the 'illegal' flag.
module rv_multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             zero,
  input  logic             lt,
  input  logic             ltu,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_sel,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             RegWrite,
  output logic [1:0]       wb_sel,
  output logic             ALUSrc,
  output logic             ALU_En,
  output logic [1:0]       aluop,
  output logic [3:0]       state,
`ifdef ILLEGAL_TRAP_EN
  output logic             illegal,
`endif
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_EXEC_R = 4'd2,  S_EXEC_I = 4'd3,
    S_ADDR   = 4'd4,  S_MEM_RD = 4'd5,  S_MEM_WR = 4'd6,  S_WB_ALU = 4'd7,
    S_WB_MEM = 4'd8,  S_BRANCH = 4'd9,  S_JAL    = 4'd10, S_JALR   = 4'd11,
    S_LUI    = 4'd12, S_TRAP   = 4'd13
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] instret_reg;
  logic             retire;
  logic             taken;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_FETCH;
      instret_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (retire)
        instret_reg <= instret_reg + CNT_W'(1);
    end
  end

  always_comb begin
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = lt;
      3'b101:  taken = !lt;
      3'b110:  taken = ltu;
      3'b111:  taken = !ltu;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    retire     = 1'b0;
    mem_req    = 1'b0;
    mem_sel    = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    RegWrite   = 1'b0;
    wb_sel     = 2'b00;
    ALUSrc     = 1'b0;
    ALU_En     = 1'b0;
    aluop      = 2'b00;
    case (state_reg)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_R:               state_next = S_EXEC_R;
          OP_I:               state_next = S_EXEC_I;
          OP_LOAD, OP_STORE:  state_next = S_ADDR;
          OP_BRANCH:          state_next = S_BRANCH;
          OP_JAL:             state_next = S_JAL;
          OP_JALR:            state_next = S_JALR;
          OP_LUI:             state_next = S_LUI;
          default: begin
`ifdef ILLEGAL_TRAP_EN
            state_next = S_TRAP;
`else
            state_next = S_FETCH;
            retire     = 1'b1;
`endif
          end
        endcase
      end
      S_EXEC_R: begin
        ALU_En = 1'b1; aluop = 2'b10; state_next = S_WB_ALU;
      end
      S_EXEC_I: begin
        ALU_En = 1'b1; ALUSrc = 1'b1; aluop = 2'b11; state_next = S_WB_ALU;
      end
      S_WB_ALU: begin
        RegWrite = 1'b1; state_next = S_FETCH; retire = 1'b1;
      end
      S_ADDR: begin
        ALU_En = 1'b1; ALUSrc = 1'b1;
        state_next = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req = 1'b1; mem_sel = 1'b1; MemRead = 1'b1;
        if (mem_ready) state_next = S_WB_MEM;
      end
      S_MEM_WR: begin
        mem_req = 1'b1; mem_sel = 1'b1; MemWrite = 1'b1;
        if (mem_ready) begin
          state_next = S_FETCH; retire = 1'b1;
        end
      end
      S_WB_MEM: begin
        RegWrite = 1'b1; wb_sel = 2'b01; state_next = S_FETCH; retire = 1'b1;
      end
      S_BRANCH: begin
        ALU_En = 1'b1; aluop = 2'b01;
        if (taken) begin
          pc_write = 1'b1; pc_src = 2'b01;
        end
        state_next = S_FETCH; retire = 1'b1;
      end
      S_JAL: begin
        RegWrite = 1'b1; wb_sel = 2'b10; pc_write = 1'b1; pc_src = 2'b01;
        state_next = S_FETCH; retire = 1'b1;
      end
      S_JALR: begin
        ALU_En = 1'b1; ALUSrc = 1'b1; RegWrite = 1'b1; wb_sel = 2'b10;
        pc_write = 1'b1; pc_src = 2'b10;
        state_next = S_FETCH; retire = 1'b1;
      end
      S_LUI: begin
        RegWrite = 1'b1; wb_sel = 2'b11; state_next = S_FETCH; retire = 1'b1;
      end
      S_TRAP:  state_next = S_TRAP;
      default: state_next = S_FETCH;
    endcase
    // Reset silences every strobe immediately, aborting any pending memory request.
    if (reset) begin
      state_next = S_FETCH;
      retire     = 1'b0;
      mem_req    = 1'b0;
      mem_sel    = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 2'b00;
      RegWrite   = 1'b0;
      wb_sel     = 2'b00;
      ALUSrc     = 1'b0;
      ALU_En     = 1'b0;
      aluop      = 2'b00;
    end
  end

  assign state   = reset ? 4'd0 : state_reg;
  assign instret = reset ? '0 : instret_reg;
`ifdef ILLEGAL_TRAP_EN
  assign illegal = !reset && (state_reg == S_TRAP);
`endif

endmodule

// File: doc/rv_multicycle_ctrl.md
Name: rv_multicycle_ctrl

Overview:
Multi-cycle control sequencer for the RV32I core datapath (PC, instruction register, register file, ALU, shared instruction/data memory port). It decodes the registered opcode/funct3 and steps the datapath through fetch, decode, execute, memory and writeback states. It drives RegWrite/MemRead/MemWrite/ALUSrc/ALU_En/aluop and PC/IR write enables, and handshakes with the memory port via mem_req/mem_ready.

Parameters:
CNT_W, 32, width of retired-instruction counter instret

Ports:
clk  input  1  core clock, all state updates on rising edge
reset  input  1  synchronous, active-high; returns block to FETCH
opcode  input  7  IR[6:0], stable from DECODE until next FETCH
funct3  input  3  IR[14:12]
zero  input  1  ALU result == 0
lt  input  1  ALU signed less-than
ltu  input  1  ALU unsigned less-than
mem_ready  input  1  memory completes current request this cycle
mem_req  output  1  memory request, held until mem_ready
mem_sel  output  1  0 = instruction fetch, 1 = data access
MemRead  output  1  data read strobe
MemWrite  output  1  data write strobe
ir_write  output  1  load IR (FETCH and mem_ready)
pc_write  output  1  load PC from pc_src mux
pc_src  output  2  00 pc+4, 01 pc+imm, 10 ALU result (JALR)
RegWrite  output  1  register file write enable
wb_sel  output  2  00 ALU, 01 memory, 10 pc+4, 11 immediate
ALUSrc  output  1  0 = rs2, 1 = immediate
ALU_En  output  1  ALU active
aluop  output  2  00 add, 01 compare/sub, 10 R-type funct, 11 I-type funct
state  output  4  current state encoding (debug)
instret  output  CNT_W  retired instruction count

Behaviour:
- Mealy on ir_write/pc_write/MemRead/MemWrite qualification by mem_ready; all other outputs decoded from state + opcode.
- Reset (sync): state=FETCH(0), instret=0; while reset is high every output 0 except state=0.
- States: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, ADDR=4, MEM_RD=5, MEM_WR=6, WB_ALU=7, WB_MEM=8, BRANCH=9, JAL=10, JALR=11, LUI=12, TRAP=13.
- FETCH: mem_req=1, mem_sel=0; on mem_ready: ir_write=1, pc_write=1, pc_src=00 -> DECODE; else stay.
- DECODE (1 cycle), by opcode: 0110011 -> EXEC_R; 0010011 -> EXEC_I; 0000011/0100011 -> ADDR; 1100011 -> BRANCH; 1101111 -> JAL; 1100111 -> JALR; 0110111 -> LUI; any other -> illegal handling (see Optional Feature).
- EXEC_R: ALU_En=1, ALUSrc=0, aluop=10 -> WB_ALU. EXEC_I: ALU_En=1, ALUSrc=1, aluop=11 -> WB_ALU.
- WB_ALU: RegWrite=1, wb_sel=00 -> FETCH; retires.
- ADDR: ALU_En=1, ALUSrc=1, aluop=00 -> MEM_RD (load) or MEM_WR (store).
- MEM_RD: mem_req=1, mem_sel=1, MemRead=1; on mem_ready -> WB_MEM. WB_MEM: RegWrite=1, wb_sel=01 -> FETCH; retires.
- MEM_WR: mem_req=1, mem_sel=1, MemWrite=1 only while waiting/at ready; on mem_ready -> FETCH; retires.
- BRANCH: ALU_En=1, ALUSrc=0, aluop=01; taken = funct3 000:zero, 001:!zero, 100:lt, 101:!lt, 110:ltu, 111:!ltu, 010/011: not taken. taken -> pc_write=1, pc_src=01. Always -> FETCH; retires.
- JAL: RegWrite=1, wb_sel=10, pc_write=1, pc_src=01 -> FETCH. JALR: ALU_En=1, ALUSrc=1, aluop=00, RegWrite=1, wb_sel=10, pc_write=1, pc_src=10 -> FETCH. LUI: RegWrite=1, wb_sel=11 -> FETCH. All retire.
- Note: PC already holds pc+4 after FETCH; datapath supplies old-PC-based targets.
- instret increments by 1 on each retiring transition to FETCH; wraps modulo 2^CNT_W.
- mem_req never dropped before mem_ready except by reset; reset during wait aborts request next edge.
- mem_ready outside FETCH/MEM_RD/MEM_WR ignored.

Optional Feature:
ILLEGAL_TRAP_EN: defined -> illegal opcode in DECODE -> TRAP; TRAP holds all enables 0, mem_req=0, no retire, exits only on reset; extra output illegal (1 bit) high in TRAP. Undefined -> illegal opcode treated as NOP: DECODE -> FETCH, retires, no illegal port.

Test Plan:
- reset high 3 cycles mid-MEM_RD wait -> state=0, mem_req=0, instret=0 next edge.
- ADD (0110011), mem_ready=1 in FETCH -> states 0,1,2,7,0; RegWrite=1 only in WB_ALU; instret=1.
- LW with mem_ready low 3 cycles in MEM_RD -> MemRead/mem_req held 4 cycles, then WB_MEM wb_sel=01, RegWrite=1.
- BEQ zero=1 -> pc_write=1, pc_src=01 in BRANCH; BNE zero=1 -> pc_write=0; funct3=010 -> not taken.
- JALR -> pc_src=10, wb_sel=10, RegWrite=1 same cycle; LUI -> wb_sel=11.
- opcode 0000000 -> with ILLEGAL_TRAP_EN: state=13, illegal=1, instret frozen; without: back to FETCH, instret+1.
